// File: rtl/bitblade_pkg.sv
// Shared types and widths for the BitBlade column feeder.
// frame_cfg_t is the per-frame configuration latched on the lane-0 beat.
package bitblade_pkg;

  localparam int LANE_W  = 32;
  localparam int LANES   = 16;
  localparam int SHIFT_W = 3;

  typedef struct packed {
    logic [3:0]               sign_x;
    logic [3:0]               sign_y;
    logic [LANES*SHIFT_W-1:0] signal;
    logic [1:0]               bitwidth;
    logic                     last;
  } frame_cfg_t;

endpackage

// File: rtl/feeder_delay_line.sv
// Fixed-depth valid/tag shift register that models the column pipeline latency.
// The tag is only carried alongside a valid bit, so idle slots hold zero.
module feeder_delay_line #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];

  always_comb begin
    vld_d[0] = in_valid;
    tag_d[0] = in_valid ? in_tag : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/bitblade_column_feeder.sv
// Ping-pong frame store feeding the BitBlade column: fills one bank from the
// source stream while the other waits to be issued for a single cycle.
module bitblade_column_feeder
  import bitblade_pkg::*;
#(
  parameter int LANES          = bitblade_pkg::LANES,
  parameter int COLUMN_LATENCY = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANE_W-1:0]          in_input_word,
  input  logic [LANE_W-1:0]          in_weight_word,
  input  logic                       in_last,
  input  logic [3:0]                 cfg_sign_x,
  input  logic [3:0]                 cfg_sign_y,
  input  logic [LANES*SHIFT_W-1:0]   cfg_signal,
  input  logic [1:0]                 cfg_bitwidth,
  input  logic                       col_stall,
  output logic [LANES*LANE_W-1:0]    packed_input_bus,
  output logic [LANES*LANE_W-1:0]    weight_bus,
  output logic [3:0]                 sign_x,
  output logic [3:0]                 sign_y,
  output logic [LANES*SHIFT_W-1:0]   signal,
  output logic [1:0]                 input_bitwidth,
  output logic                       issue_valid,
  output logic                       result_valid,
  output logic                       result_last,
  output logic [15:0]                frames_issued
);

  localparam int CNT_W = $clog2(LANES);

  logic [LANE_W-1:0] bank_in_q [2][LANES];
  logic [LANE_W-1:0] bank_wt_q [2][LANES];

  frame_cfg_t                cfg_q [2];
  frame_cfg_t                cfg_d [2];
  logic [1:0]                full_q, full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]          lane_cnt_q, lane_cnt_d;
  logic [15:0]               frames_q, frames_d;
  logic [LANES*LANE_W-1:0]   in_bus_q, in_bus_d;
  logic [LANES*LANE_W-1:0]   wt_bus_q, wt_bus_d;
  frame_cfg_t                out_cfg_q, out_cfg_d;
  logic                      issue_q, issue_d;

  logic accept, lane_last, issue;

  assign in_ready = !full_q[wr_bank_q];

  always_comb begin
    accept     = in_valid && in_ready;
    lane_last  = (lane_cnt_q == CNT_W'(LANES-1));
    issue      = full_q[rd_bank_q] && !col_stall;

    cfg_d      = cfg_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    lane_cnt_d = lane_cnt_q;
    frames_d   = frames_q;
    in_bus_d   = '0;
    wt_bus_d   = '0;
    out_cfg_d  = out_cfg_q;
    issue_d    = issue;

    if (accept) begin
      lane_cnt_d = lane_last ? '0 : lane_cnt_q + 1'b1;
      if (lane_cnt_q == '0) begin
        cfg_d[wr_bank_q] = '{sign_x:   cfg_sign_x,
                             sign_y:   cfg_sign_y,
                             signal:   cfg_signal,
                             bitwidth: cfg_bitwidth,
                             last:     in_last};
      end
      if (lane_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // A fill can only target an empty bank and an issue only a full one,
    // so the two updates to full_d never touch the same bit.
    if (issue) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frames_d          = frames_q + 16'd1;
      out_cfg_d         = cfg_q[rd_bank_q];
      for (int k = 0; k < LANES; k++) begin
        in_bus_d[k*LANE_W +: LANE_W] = bank_in_q[rd_bank_q][k];
        wt_bus_d[k*LANE_W +: LANE_W] = bank_wt_q[rd_bank_q][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bank_in_q[wr_bank_q][lane_cnt_q] <= in_input_word;
      bank_wt_q[wr_bank_q][lane_cnt_q] <= in_weight_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q[0]   <= '0;
      cfg_q[1]   <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      lane_cnt_q <= '0;
      frames_q   <= '0;
      in_bus_q   <= '0;
      wt_bus_q   <= '0;
      out_cfg_q  <= '0;
      issue_q    <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      lane_cnt_q <= lane_cnt_d;
      frames_q   <= frames_d;
      in_bus_q   <= in_bus_d;
      wt_bus_q   <= wt_bus_d;
      out_cfg_q  <= out_cfg_d;
      issue_q    <= issue_d;
    end
  end

  assign packed_input_bus = in_bus_q;
  assign weight_bus       = wt_bus_q;
  assign sign_x           = out_cfg_q.sign_x;
  assign sign_y           = out_cfg_q.sign_y;
  assign signal           = out_cfg_q.signal;
  assign input_bitwidth   = out_cfg_q.bitwidth;
  assign issue_valid      = issue_q;
  assign frames_issued    = frames_q;

  feeder_delay_line #(
    .DEPTH (COLUMN_LATENCY),
    .TAG_W (1)
  ) u_delay (
    .clk       (clk),
    .rst_n     (reset),
    .in_valid  (issue_q),
    .in_tag    (issue_q & out_cfg_q.last),
    .out_valid (result_valid),
    .out_tag   (result_last)
  );

endmodule
